// File: rtl/wb_arb2_mem.sv
// Two-master Wishbone arbiter in front of a single memory slave.
// Round-robin on ties, no preemption, and a per-transfer watchdog that
// answers a stuck strobe with a one-cycle ERR to the granted master.
//
// state  | meaning
// IDLE   | no master owns the slave, slave request side driven to zero
// GRANT0 | master 0 owns the slave until it drops M0_CYC_I
// GRANT1 | master 1 owns the slave until it drops M1_CYC_I
module wb_arb2_mem #(
    parameter int AW  = 3,
    parameter int DW  = 32,
    parameter int TMO = 15
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          M0_CYC_I,
    input  logic          M0_STB_I,
    input  logic          M0_WE_I,
    input  logic [AW-1:0] M0_ADR_I,
    input  logic [DW-1:0] M0_DAT_I,
    output logic [DW-1:0] M0_DAT_O,
    output logic          M0_ACK_O,
    output logic          M0_ERR_O,
    input  logic          M1_CYC_I,
    input  logic          M1_STB_I,
    input  logic          M1_WE_I,
    input  logic [AW-1:0] M1_ADR_I,
    input  logic [DW-1:0] M1_DAT_I,
    output logic [DW-1:0] M1_DAT_O,
    output logic          M1_ACK_O,
    output logic          M1_ERR_O,
    output logic          S_STB_O,
    output logic          S_WE_O,
    output logic [AW-1:0] S_ADR_O,
    output logic [DW-1:0] S_DAT_O,
    input  logic [DW-1:0] S_DAT_I,
    input  logic          S_ACK_I,
    output logic [1:0]    GNT_O
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       last_gnt;     // 1: master 1 was the last owner
    logic [7:0] wd_cnt;

    logic granted;
    logic cyc_g;
    logic stb_g;
    logic req;
    logic expire;
    logic ack_g;
    logic err_g;

    assign granted = (state != IDLE);
    assign GNT_O   = {state == GRANT1, state == GRANT0};

    // Route the owning master onto the slave request side; zeros when idle.
    always_comb begin
        cyc_g   = 1'b0;
        stb_g   = 1'b0;
        S_WE_O  = 1'b0;
        S_ADR_O = '0;
        S_DAT_O = '0;
        case (state)
            GRANT0: begin
                cyc_g   = M0_CYC_I;
                stb_g   = M0_STB_I;
                S_WE_O  = M0_WE_I;
                S_ADR_O = M0_ADR_I;
                S_DAT_O = M0_DAT_I;
            end
            GRANT1: begin
                cyc_g   = M1_CYC_I;
                stb_g   = M1_STB_I;
                S_WE_O  = M1_WE_I;
                S_ADR_O = M1_ADR_I;
                S_DAT_O = M1_DAT_I;
            end
            default: ;
        endcase
    end

    // A slave ACK in the last watchdog cycle wins over the timeout.
    // Outputs are held quiet while reset is high so an aborted transfer
    // never completes or errors in the cycle it is killed.
    assign req      = granted & cyc_g & stb_g;
    assign expire   = req & ~S_ACK_I & (wd_cnt == 8'(TMO - 1));
    assign S_STB_O  = req & ~expire & ~RST_I;
    assign ack_g    = S_ACK_I & granted & stb_g & ~RST_I;
    assign err_g    = expire & ~RST_I;

    assign M0_ACK_O = ack_g & (state == GRANT0);
    assign M1_ACK_O = ack_g & (state == GRANT1);
    assign M0_ERR_O = err_g & (state == GRANT0);
    assign M1_ERR_O = err_g & (state == GRANT1);
    assign M0_DAT_O = S_DAT_I;
    assign M1_DAT_O = S_DAT_I;

    // Next owner: round-robin on ties from idle, hold while CYC stays high.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (M0_CYC_I && M1_CYC_I) state_nxt = last_gnt ? GRANT0 : GRANT1;
                else if (M0_CYC_I)        state_nxt = GRANT0;
                else if (M1_CYC_I)        state_nxt = GRANT1;
            end
            GRANT0: if (!M0_CYC_I) state_nxt = M1_CYC_I ? GRANT1 : IDLE;
            GRANT1: if (!M1_CYC_I) state_nxt = M0_CYC_I ? GRANT0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant state, last-owner memory and watchdog counter.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            wd_cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == GRANT0 && !M0_CYC_I) last_gnt <= 1'b0;
            if (state == GRANT1 && !M1_CYC_I) last_gnt <= 1'b1;
            if (state_nxt != state || !S_STB_O || S_ACK_I) wd_cnt <= 8'd0;
            else                                           wd_cnt <= wd_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_wb_arb2_mem.sv
// Bench for wb_arb2_mem: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of ownership and strobe waiting time.
module tb_wb_arb2_mem;

    localparam int AW  = 3;
    localparam int DW  = 32;
    localparam int TMO = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cyc [2];
    logic          stb [2];
    logic          we  [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] dat [2];
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic          s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat;
    logic [DW-1:0] s_dat_i;
    logic          s_ack;
    logic [1:0]    gnt;

    wb_arb2_mem #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .CLK_I(clk), .RST_I(rst),
        .M0_CYC_I(cyc[0]), .M0_STB_I(stb[0]), .M0_WE_I(we[0]),
        .M0_ADR_I(adr[0]), .M0_DAT_I(dat[0]),
        .M0_DAT_O(m0_dat_o), .M0_ACK_O(m0_ack), .M0_ERR_O(m0_err),
        .M1_CYC_I(cyc[1]), .M1_STB_I(stb[1]), .M1_WE_I(we[1]),
        .M1_ADR_I(adr[1]), .M1_DAT_I(dat[1]),
        .M1_DAT_O(m1_dat_o), .M1_ACK_O(m1_ack), .M1_ERR_O(m1_err),
        .S_STB_O(s_stb), .S_WE_O(s_we), .S_ADR_O(s_adr), .S_DAT_O(s_dat),
        .S_DAT_I(s_dat_i), .S_ACK_I(s_ack), .GNT_O(gnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: who owns the slave (-1 none), who owned it last,
    // and how many cycles the current strobe has gone unanswered.
    int owner    = -1;
    int last_own = 1;
    int waits    = 0;
    bit cmp_on   = 1'b0;
    bit m_sstb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic compare();
        logic [1:0]    e_gnt;
        logic          e_swe;
        logic [AW-1:0] e_sadr;
        logic [DW-1:0] e_sdat;
        logic          e_ack [2];
        logic          e_err [2];
        bit            req, expire;
        e_gnt  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        e_swe  = 1'b0;
        e_sadr = '0;
        e_sdat = '0;
        e_ack  = '{1'b0, 1'b0};
        e_err  = '{1'b0, 1'b0};
        m_sstb = 1'b0;
        if (owner >= 0) begin
            req    = cyc[owner] && stb[owner];
            expire = req && !s_ack && (waits == TMO - 1);
            m_sstb = req && !expire && !rst;
            e_swe  = we[owner];
            e_sadr = adr[owner];
            e_sdat = dat[owner];
            e_ack[owner] = s_ack && stb[owner] && !rst;
            e_err[owner] = expire && !rst;
        end
        chk("gnt",    64'(gnt),      64'(e_gnt));
        chk("s_stb",  64'(s_stb),    64'(m_sstb));
        chk("s_we",   64'(s_we),     64'(e_swe));
        chk("s_adr",  64'(s_adr),    64'(e_sadr));
        chk("s_dat",  64'(s_dat),    64'(e_sdat));
        chk("m0_ack", 64'(m0_ack),   64'(e_ack[0]));
        chk("m1_ack", 64'(m1_ack),   64'(e_ack[1]));
        chk("m0_err", 64'(m0_err),   64'(e_err[0]));
        chk("m1_err", 64'(m1_err),   64'(e_err[1]));
        chk("m0_dat", 64'(m0_dat_o), 64'(s_dat_i));
        chk("m1_dat", 64'(m1_dat_o), 64'(s_dat_i));
    endtask

    task automatic update();
        int nxt;
        if (rst) begin
            owner = -1; last_own = 1; waits = 0;
            return;
        end
        if (owner < 0) begin
            if (cyc[0] && cyc[1]) nxt = 1 - last_own;
            else if (cyc[0])      nxt = 0;
            else if (cyc[1])      nxt = 1;
            else                  nxt = -1;
        end else if (cyc[owner]) begin
            nxt = owner;
        end else begin
            last_own = owner;
            nxt = cyc[1 - owner] ? 1 - owner : -1;
        end
        if (nxt != owner || !m_sstb || s_ack) waits = 0;
        else                                  waits++;
        owner = nxt;
    endtask

    // One clock: settle, compare against the model, advance at the edge.
    task automatic cycle();
        #2;
        if (cmp_on) compare();
        else m_sstb = 1'b0;
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; dat[i] = '0;
        end
        s_ack = 1'b0;
        s_dat_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        cycle();
        cmp_on = 1'b1;
        cycle();
        #2;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_stb", 64'(s_stb), 64'd0);
        rst = 1'b0;

        // single master write
        cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 3'd5; dat[0] = 32'hA5A5A5A5;
        cycle();
        s_ack = 1; s_dat_i = 32'h1234_5678;
        #2;
        chk("sm_gnt",  64'(gnt),    64'h1);
        chk("sm_adr",  64'(s_adr),  64'd5);
        chk("sm_sdat", 64'(s_dat),  64'hA5A5A5A5);
        chk("sm_ack0", 64'(m0_ack), 64'd1);
        chk("sm_ack1", 64'(m1_ack), 64'd0);
        cycle();
        idle_inputs();
        cycle();
        cycle();

        // tie from reset, then alternation
        do_reset();
        cyc[0] = 1; cyc[1] = 1;
        cycle();
        #2; chk("tie_first", 64'(gnt), 64'h1);
        cycle();
        cyc[0] = 0;
        cycle();
        #2; chk("tie_second", 64'(gnt), 64'h2);
        cycle();
        cyc[1] = 0;
        cycle();
        cyc[0] = 1; cyc[1] = 1;
        cycle();
        #2; chk("tie_alt", 64'(gnt), 64'h1);
        cycle();
        idle_inputs();
        cycle();

        // no preemption of master 1 over 8 transfers
        cyc[1] = 1; stb[1] = 1; adr[1] = 3'd2; s_ack = 1;
        cycle();
        cyc[0] = 1; stb[0] = 1;
        for (int k = 0; k < 8; k++) begin
            dat[1] = $urandom;
            #2;
            chk("np_gnt",  64'(gnt),    64'h2);
            chk("np_ack0", 64'(m0_ack), 64'd0);
            chk("np_ack1", 64'(m1_ack), 64'd1);
            cycle();
        end
        idle_inputs();
        cycle();
        cycle();

        // watchdog timeout on master 0
        do_reset();
        cyc[0] = 1; stb[0] = 1;
        cycle();
        for (int k = 1; k <= 20; k++) begin
            #2;
            chk("to_err0", 64'(m0_err), (k == TMO) ? 64'd1 : 64'd0);
            chk("to_stb",  64'(s_stb),  (k == TMO) ? 64'd0 : 64'd1);
            chk("to_ack0", 64'(m0_ack), 64'd0);
            cycle();
        end
        idle_inputs();
        cycle();

        // ACK arriving in the expire cycle wins
        do_reset();
        cyc[0] = 1; stb[0] = 1;
        cycle();
        for (int k = 1; k <= TMO; k++) begin
            if (k == TMO) s_ack = 1;
            #2;
            if (k == TMO) begin
                chk("race_ack0", 64'(m0_ack), 64'd1);
                chk("race_err0", 64'(m0_err), 64'd0);
            end
            cycle();
        end
        idle_inputs();
        cycle();

        // reset while master 1 has a strobe pending
        do_reset();
        cyc[1] = 1; stb[1] = 1;
        cycle();
        cycle();
        #2; chk("mr_gnt_before", 64'(gnt), 64'h2);
        rst = 1; s_ack = 1;
        cycle();
        rst = 0; s_ack = 0;
        #2;
        chk("mr_gnt",  64'(gnt),    64'd0);
        chk("mr_stb",  64'(s_stb),  64'd0);
        chk("mr_ack1", 64'(m1_ack), 64'd0);
        chk("mr_err1", 64'(m1_err), 64'd0);
        cycle();

        // random traffic in three slave-responsiveness phases
        do_reset();
        for (int p = 0; p < 3; p++) begin
            int pct;
            pct = (p == 0) ? 70 : (p == 1) ? 25 : 2;
            for (int n = 0; n < 1500; n++) begin
                for (int i = 0; i < 2; i++) begin
                    if ($urandom_range(0, 7) == 0) cyc[i] = ~cyc[i];
                    if ($urandom_range(0, 5) == 0) stb[i] = ~stb[i];
                    we[i]  = 1'($urandom);
                    adr[i] = AW'($urandom);
                    dat[i] = $urandom;
                end
                s_ack   = ($urandom_range(0, 99) < pct);
                s_dat_i = $urandom;
                rst     = ($urandom_range(0, 299) == 0);
                cycle();
            end
        end
        rst = 0;
        idle_inputs();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_arb2_mem.md
WB_ARB2_MEM -- requirements
Module: wb_arb2_mem

Interface
REQ-001 SHALL have parameter AW, default 3, meaning address width in bits.
REQ-002 SHALL have parameter DW, default 32, meaning data width in bits.
REQ-003 SHALL have parameter TMO, default 15, meaning watchdog limit in cycles (STB held without ACK), legal range 2..255.
REQ-004 SHALL have port CLK_I  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST_I  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports M0_CYC_I/M1_CYC_I  in  1  master bus-cycle request.
REQ-007 SHALL have ports M0_STB_I/M1_STB_I  in  1  master strobe.
REQ-008 SHALL have ports M0_WE_I/M1_WE_I  in  1  master write enable.
REQ-009 SHALL have ports M0_ADR_I/M1_ADR_I  in  AW  master address.
REQ-010 SHALL have ports M0_DAT_I/M1_DAT_I  in  DW  master write data.
REQ-011 SHALL have ports M0_DAT_O/M1_DAT_O  out  DW  read data to master.
REQ-012 SHALL have ports M0_ACK_O/M1_ACK_O  out  1  acknowledge to master.
REQ-013 SHALL have ports M0_ERR_O/M1_ERR_O  out  1  watchdog error to master.
REQ-014 SHALL have ports S_STB_O  out  1, S_WE_O  out  1, S_ADR_O  out  AW, S_DAT_O  out  DW: slave (memory) request side.
REQ-015 SHALL have ports S_DAT_I  in  DW, S_ACK_I  in  1: slave response side.
REQ-016 SHALL have port GNT_O  out  2  one-hot current grant (bit n = master n), 00 when idle.

Function
REQ-017 SHALL implement a registered FSM with states IDLE, GRANT0, GRANT1; GNT_O decoded from state.
REQ-018 IDLE: if exactly one CYC_I high, SHALL enter that master's GRANT state next cycle (one-cycle grant latency).
REQ-019 IDLE with both CYC_I high SHALL grant the master not granted last (round-robin via a last-grant register).
REQ-020 GRANTn SHALL persist while Mn_CYC_I high, regardless of the other master's CYC_I (no preemption).
REQ-021 GRANTn with Mn_CYC_I low SHALL move next cycle to GRANTm if Mm_CYC_I high, else IDLE; last-grant register updates to n.
REQ-022 In GRANTn, S_STB_O SHALL equal Mn_CYC_I AND Mn_STB_I AND NOT watchdog-expire; S_WE_O, S_ADR_O, S_DAT_O SHALL combinationally follow master n.
REQ-023 In IDLE, S_STB_O, S_WE_O SHALL be 0 and S_ADR_O, S_DAT_O SHALL be 0.
REQ-024 Mn_ACK_O SHALL equal S_ACK_I AND (state==GRANTn) AND Mn_STB_I; the non-granted master's ACK_O SHALL be 0.
REQ-025 M0_DAT_O and M1_DAT_O SHALL both carry S_DAT_I unregistered; validity is qualified only by ACK_O.
REQ-026 Watchdog: 8-bit counter SHALL increment each cycle S_STB_O high and S_ACK_I low, clear on S_ACK_I, on state change, or when S_STB_O low.
REQ-027 When counter reaches TMO-1 with S_ACK_I still low, that cycle SHALL be the expire cycle: Mn_ERR_O high for exactly one cycle, S_STB_O forced low, counter cleared.
REQ-028 S_ACK_I high in the expire cycle SHALL take precedence: ACK_O issued, ERR_O not asserted.
REQ-029 S_ACK_I received while IDLE or while granted master's STB_I low SHALL be ignored (no ACK_O to any master).
REQ-030 ERR_O and ACK_O to the same master SHALL never be high in the same cycle.

Reset
REQ-031 RST_I high at a rising edge SHALL force state IDLE, last-grant = master 1 (so master 0 wins the first tie), watchdog counter 0, overriding all other inputs.
REQ-032 During and after reset until a grant: GNT_O=00, S_STB_O=0, S_WE_O=0, all ACK_O=0, all ERR_O=0.
REQ-033 Reset asserted mid-transfer SHALL abort the grant in the next cycle with no ACK_O or ERR_O produced for that transfer.

Verification
REQ-034 Single master: M0 CYC/STB/WE=1, ADR=5, DAT=0xA5A5A5A5, slave acks next cycle -> GNT_O=01 one cycle after CYC, S_ADR_O=5, M0_ACK_O pulse; M1 outputs stay 0.
REQ-035 Tie from reset: both CYC_I rise same cycle -> GNT_O=01 first; M0 drops CYC -> GNT_O=10 next cycle; both request again after release -> GNT_O=01 (alternation).
REQ-036 No preemption: M1 holds CYC for 8 transfers while M0 requests -> GNT_O stays 10 for all 8, M0_ACK_O=0 throughout.
REQ-037 Timeout: granted M0 strobes, S_ACK_I held 0 -> M0_ERR_O high exactly at the 15th strobe cycle, S_STB_O low that cycle, M0_ACK_O never high.
REQ-038 Race: S_ACK_I arrives in the 15th cycle -> M0_ACK_O=1, M0_ERR_O=0.
REQ-039 Reset mid-operation: RST_I pulsed while GNT_O=10 with strobe pending -> next cycle GNT_O=00, S_STB_O=0, no ACK_O/ERR_O.
